// File: rtl/vga_pkg.sv
// Shared VGA scan-out constants, pixel type and the control bundle that travels
// down the alignment pipeline alongside each pixel.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int VGA_SCALE_SH = 1;
   localparam int VGA_ADDR_W   = 17;
   localparam int VGA_RAM_LAT  = 1;
   localparam int VGA_PIX_W    = 12;

   localparam int VGA_FB_W     = VGA_H_ACTIVE >> VGA_SCALE_SH;
   localparam int VGA_FB_H     = VGA_V_ACTIVE >> VGA_SCALE_SH;
   localparam int VGA_FB_LAST  = VGA_FB_W * VGA_FB_H - 1;

   typedef logic [VGA_PIX_W-1:0] rgb444_t;

   // act = visible pixel, hs/vs = active-low syncs, fs = frame origin (0,0)
   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
      logic fs;
   } vga_ctl_t;

   localparam vga_ctl_t CTL_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

endpackage

// File: rtl/vga_fb_scan_if.sv
// Frame-buffer read port plus the pixel/sync stream handed to the RGB converter.
interface vga_fb_scan_if #(
   parameter int ADDR_W = vga_pkg::VGA_ADDR_W
);
   import vga_pkg::*;

   logic [ADDR_W-1:0] Addr;
   logic              Rd_en;
   rgb444_t           Din;
   rgb444_t           Dout;
   logic              Nblank;
   logic              Hsync;
   logic              Vsync;
   logic              Frame_start;

   modport master (
      output Addr, Rd_en, Dout, Nblank, Hsync, Vsync, Frame_start,
      input  Din
   );

   modport slave (
      input  Addr, Rd_en, Dout, Nblank, Hsync, Vsync, Frame_start,
      output Din
   );

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running horizontal/vertical counters and the stage-0 decode of
// visibility, sync and frame-origin flags for the scan-out pipeline.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int SCALE_SH = VGA_SCALE_SH
)(
   input  logic     CLK,
   input  logic     Nreset,
   output vga_ctl_t o_ctl,
   output logic     o_h_wrap,
   output logic     o_line_step,
   output logic     o_v_wrap
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HCNT_W  = $clog2(H_TOTAL);
   localparam int VCNT_W  = $clog2(V_TOTAL);

   logic [HCNT_W-1:0] r_hcnt;
   logic [VCNT_W-1:0] r_vcnt;
   logic              w_h_last;
   logic              w_v_last;
   logic              w_act;
   logic              w_hs;
   logic              w_vs;
   logic              w_fs;

   assign w_h_last = (r_hcnt == HCNT_W'(H_TOTAL - 1));
   assign w_v_last = (r_vcnt == VCNT_W'(V_TOTAL - 1));

   always_ff @(posedge CLK) begin
      if (!Nreset) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (w_h_last) begin
         r_hcnt <= '0;
         r_vcnt <= w_v_last ? '0 : r_vcnt + VCNT_W'(1);
      end else begin
         r_hcnt <= r_hcnt + HCNT_W'(1);
      end
   end

   assign w_act = (r_hcnt < HCNT_W'(H_ACTIVE)) && (r_vcnt < VCNT_W'(V_ACTIVE));
   assign w_hs  = !((r_hcnt >= HCNT_W'(H_ACTIVE + H_FP)) &&
                    (r_hcnt <  HCNT_W'(H_ACTIVE + H_FP + H_SYNC)));
   assign w_vs  = !((r_vcnt >= VCNT_W'(V_ACTIVE + V_FP)) &&
                    (r_vcnt <  VCNT_W'(V_ACTIVE + V_FP + V_SYNC)));
   assign w_fs  = (r_hcnt == '0) && (r_vcnt == '0);

   assign o_ctl = '{act: w_act, hs: w_hs, vs: w_vs, fs: w_fs};

   // The last source line of each replicated group advances the buffer row.
   assign o_h_wrap    = w_h_last;
   assign o_v_wrap    = w_h_last && w_v_last;
   assign o_line_step = w_h_last && (&r_vcnt[SCALE_SH-1:0]) &&
                        (r_vcnt < VCNT_W'(V_ACTIVE));

endmodule

// File: rtl/vga_fb_scan.sv
// VGA scan-out: frame-buffer address generation with pixel/line replication,
// and a two-stage pipeline aligning returned pixels with Nblank/Hsync/Vsync.
module vga_fb_scan
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int SCALE_SH = VGA_SCALE_SH,
   parameter int ADDR_W   = VGA_ADDR_W
)(
   input  logic          CLK,
   input  logic          Nreset,
   vga_fb_scan_if.master bus
);

   localparam int FB_W = H_ACTIVE >> SCALE_SH;

   vga_ctl_t            w_ctl;
   logic                w_h_wrap;
   logic                w_line_step;
   logic                w_v_wrap;

   logic [ADDR_W-1:0]   r_line_base;
   logic [ADDR_W-1:0]   r_col;
   logic [SCALE_SH-1:0] r_phase;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_rd_en;
   vga_ctl_t            r_ctl_d1;
   vga_ctl_t            r_ctl_d2;
   rgb444_t             r_dout;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SCALE_SH (SCALE_SH)
   ) u_timing (
      .CLK         (CLK),
      .Nreset      (Nreset),
      .o_ctl       (w_ctl),
      .o_h_wrap    (w_h_wrap),
      .o_line_step (w_line_step),
      .o_v_wrap    (w_v_wrap)
   );

   // Row base and column are tracked incrementally so no multiplier is needed.
   always_ff @(posedge CLK) begin
      if (!Nreset) begin
         r_line_base <= '0;
         r_col       <= '0;
         r_phase     <= '0;
      end else begin
         if (w_h_wrap) begin
            r_col   <= '0;
            r_phase <= '0;
         end else if (w_ctl.act) begin
            r_phase <= r_phase + SCALE_SH'(1);
            if (&r_phase) begin
               r_col <= r_col + ADDR_W'(1);
            end
         end

         if (w_v_wrap) begin
            r_line_base <= '0;
         end else if (w_line_step) begin
            r_line_base <= r_line_base + ADDR_W'(FB_W);
         end
      end
   end

   // Stage 1 issues the read; stage 2 captures the RAM word one cycle later.
   always_ff @(posedge CLK) begin
      if (!Nreset) begin
         r_addr   <= '0;
         r_rd_en  <= 1'b0;
         r_ctl_d1 <= CTL_IDLE;
         r_ctl_d2 <= CTL_IDLE;
         r_dout   <= '0;
      end else begin
         if (w_ctl.act) begin
            r_addr <= r_line_base + r_col;
         end
         r_rd_en  <= w_ctl.act;
         r_ctl_d1 <= w_ctl;
         r_ctl_d2 <= r_ctl_d1;
         r_dout   <= r_ctl_d1.act ? bus.Din : '0;
      end
   end

   assign bus.Addr        = r_addr;
   assign bus.Rd_en       = r_rd_en;
   assign bus.Dout        = r_dout;
   assign bus.Nblank      = r_ctl_d2.act;
   assign bus.Hsync       = r_ctl_d2.hs;
   assign bus.Vsync       = r_ctl_d2.vs;
   assign bus.Frame_start = r_ctl_d2.fs;

endmodule

// File: tb/tb_vga_fb_scan.sv
// Bench for vga_fb_scan: a full 640x480 instance and a shrunken-geometry
// instance, both checked every cycle against a position-based timing model.
module tb_vga_fb_scan;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   int   mode = 1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   vga_fb_scan_if #(.ADDR_W(17)) bus_full ();
   vga_fb_scan_if #(.ADDR_W(17)) bus_small ();

   vga_fb_scan u_full (
      .CLK    (clk),
      .Nreset (nreset),
      .bus    (bus_full)
   );

   vga_fb_scan #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
      .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (2),
      .SCALE_SH (1),  .ADDR_W (17)
   ) u_small (
      .CLK    (clk),
      .Nreset (nreset),
      .bus    (bus_small)
   );

   // Geometry per instance: index 0 = full, 1 = small
   localparam int HA  [2] = '{640, 16};
   localparam int HFP [2] = '{16, 2};
   localparam int HSY [2] = '{96, 4};
   localparam int HBP [2] = '{48, 2};
   localparam int VA  [2] = '{480, 8};
   localparam int VFP [2] = '{10, 2};
   localparam int VSY [2] = '{2, 2};
   localparam int VBP [2] = '{33, 2};

   // RAM contents: 0 = low address bits, 1 = F0F only at address 5, 2 = all FFF
   function automatic logic [11:0] ram(input int m, input logic [16:0] a);
      if (m == 0) return a[11:0];
      if (m == 1) return (a == 17'd5) ? 12'hF0F : 12'h000;
      return 12'hFFF;
   endfunction

   assign bus_full.Din  = ram(mode, bus_full.Addr);
   assign bus_small.Din = ram(mode, bus_small.Addr);

   function automatic int ht(input int d);
      return HA[d] + HFP[d] + HSY[d] + HBP[d];
   endfunction
   function automatic int vt(input int d);
      return VA[d] + VFP[d] + VSY[d] + VBP[d];
   endfunction
   function automatic int hpos(input int d, input int c);
      return (c % (ht(d) * vt(d))) % ht(d);
   endfunction
   function automatic int vpos(input int d, input int c);
      return (c % (ht(d) * vt(d))) / ht(d);
   endfunction
   function automatic bit m_act(input int d, input int c);
      return hpos(d, c) < HA[d] && vpos(d, c) < VA[d];
   endfunction
   function automatic bit m_hs(input int d, input int c);
      int h;
      h = hpos(d, c);
      return !(h >= HA[d] + HFP[d] && h < HA[d] + HFP[d] + HSY[d]);
   endfunction
   function automatic bit m_vs(input int d, input int c);
      int v;
      v = vpos(d, c);
      return !(v >= VA[d] + VFP[d] && v < VA[d] + VFP[d] + VSY[d]);
   endfunction
   function automatic logic [16:0] m_addr(input int d, input int c);
      return 17'((vpos(d, c) / 2) * (HA[d] / 2) + hpos(d, c) / 2);
   endfunction

   // Model state: c0/c1/c2 = counter position now / one / two cycles ago,
   // r1/r2 = whether a reset edge closed the previous / earlier cycle.
   int          c0 = 0, c1 = 0, c2 = 0;
   bit          r1 = 1'b1, r2 = 1'b1;
   bit          started = 1'b0;
   logic [16:0] e_addr [2];
   logic        e_rd [2];
   logic [11:0] e_dout [2];
   logic        e_nb [2], e_hs [2], e_vs [2], e_fs [2];
   logic [11:0] din_prev [2];

   always @(posedge clk) begin
      bit rs;
      bit valid;
      rs = !nreset;
      for (int d = 0; d < 2; d++) din_prev[d] = ram(mode, started ? e_addr[d] : 17'd0);
      r2 = r1;
      r1 = rs;
      c2 = c1;
      c1 = c0;
      c0 = rs ? 0 : c0 + 1;
      valid = !r1 && !r2;
      for (int d = 0; d < 2; d++) begin
         if (r1) begin
            e_addr[d] = 17'd0;
            e_rd[d]   = 1'b0;
         end else if (m_act(d, c1)) begin
            e_addr[d] = m_addr(d, c1);
            e_rd[d]   = 1'b1;
         end else begin
            e_rd[d]   = 1'b0;
         end
         e_nb[d]   = valid && m_act(d, c2);
         e_hs[d]   = valid ? m_hs(d, c2) : 1'b1;
         e_vs[d]   = valid ? m_vs(d, c2) : 1'b1;
         e_fs[d]   = valid && (c2 % (ht(d) * vt(d)) == 0);
         e_dout[d] = (valid && m_act(d, c2)) ? din_prev[d] : 12'h000;
      end
      started = 1'b1;
   end

   task automatic cmp(input string name, input logic [33:0] got, input logic [33:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s t=%0t {addr,rd,dout,nb,hs,vs,fs} got=%h exp=%h", name, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         cmp("full_model",
             {bus_full.Addr, bus_full.Rd_en, bus_full.Dout, bus_full.Nblank,
              bus_full.Hsync, bus_full.Vsync, bus_full.Frame_start},
             {e_addr[0], e_rd[0], e_dout[0], e_nb[0], e_hs[0], e_vs[0], e_fs[0]});
         cmp("small_model",
             {bus_small.Addr, bus_small.Rd_en, bus_small.Dout, bus_small.Nblank,
              bus_small.Hsync, bus_small.Vsync, bus_small.Frame_start},
             {e_addr[1], e_rd[1], e_dout[1], e_nb[1], e_hs[1], e_vs[1], e_fs[1]});
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end else begin
         $display("vec %s cyc=%0d value=%h", name, cyc, got);
      end
   endtask

   task automatic step_to(input int k);
      while (cyc < k) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic hold_reset(input int n, input int new_mode);
      nreset = 1'b0;
      mode   = new_mode;
      repeat (n) @(negedge clk);
   endtask

   task automatic release_reset();
      nreset = 1'b1;
      cyc    = 0;
   endtask

   task automatic chk_reset_state();
      chk("rst_full_hs",    32'(bus_full.Hsync),  32'd1);
      chk("rst_full_vs",    32'(bus_full.Vsync),  32'd1);
      chk("rst_full_nb",    32'(bus_full.Nblank), 32'd0);
      chk("rst_full_dout",  32'(bus_full.Dout),   32'd0);
      chk("rst_full_addr",  32'(bus_full.Addr),   32'd0);
      chk("rst_full_rd",    32'(bus_full.Rd_en),  32'd0);
      chk("rst_small_addr", 32'(bus_small.Addr),  32'd0);
   endtask

   initial begin
      // Power-up reset with the alignment RAM pattern
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk_reset_state();
      release_reset();
      step_to(1);    chk("fs_c1",            32'(bus_full.Frame_start), 32'd0);
      step_to(2);    chk("fs_c2_full",       32'(bus_full.Frame_start), 32'd1);
                     chk("fs_c2_small",      32'(bus_small.Frame_start), 32'd1);
      step_to(3);    chk("fs_c3",            32'(bus_full.Frame_start), 32'd0);
      step_to(11);   chk("align_dout_11",    32'(bus_full.Dout), 32'h000);
      step_to(12);   chk("align_dout_12",    32'(bus_full.Dout), 32'hF0F);
                     chk("align_nb_12",      32'(bus_full.Nblank), 32'd1);
                     chk("align_small_12",   32'(bus_small.Dout), 32'hF0F);
      step_to(13);   chk("align_dout_13",    32'(bus_full.Dout), 32'hF0F);
      step_to(14);   chk("align_dout_14",    32'(bus_full.Dout), 32'h000);
      step_to(36);   chk("align_small_l1",   32'(bus_small.Dout), 32'hF0F);
      step_to(657);  chk("hs_657",           32'(bus_full.Hsync), 32'd1);
      step_to(658);  chk("hs_658",           32'(bus_full.Hsync), 32'd0);
      step_to(753);  chk("hs_753",           32'(bus_full.Hsync), 32'd0);
      step_to(754);  chk("hs_754",           32'(bus_full.Hsync), 32'd1);
      step_to(812);  chk("align_l1_812",     32'(bus_full.Dout), 32'hF0F);
      step_to(813);  chk("align_l1_813",     32'(bus_full.Dout), 32'hF0F);
      step_to(1700);

      // Second reset, RAM returns address bits
      hold_reset(5, 0);
      chk_reset_state();
      release_reset();
      step_to(1);    chk("addr_t1",          32'(bus_full.Addr), 32'd0);
      step_to(2);    chk("addr_t2",          32'(bus_full.Addr), 32'd0);
      step_to(3);    chk("addr_t3",          32'(bus_full.Addr), 32'd1);
      step_to(7);    chk("dout_t7",          32'(bus_full.Dout), 32'h002);
      step_to(184);  chk("small_addr_last",  32'(bus_small.Addr), 32'd31);
      step_to(185);  chk("small_addr_hold",  32'(bus_small.Addr), 32'd31);
                     chk("small_rd_off",     32'(bus_small.Rd_en), 32'd0);
      step_to(241);  chk("small_vs_241",     32'(bus_small.Vsync), 32'd1);
      step_to(242);  chk("small_vs_242",     32'(bus_small.Vsync), 32'd0);
      step_to(289);  chk("small_vs_289",     32'(bus_small.Vsync), 32'd0);
      step_to(290);  chk("small_vs_290",     32'(bus_small.Vsync), 32'd1);
      step_to(337);  chk("small_addr_wrap",  32'(bus_small.Addr), 32'd0);
                     chk("small_rd_wrap",    32'(bus_small.Rd_en), 32'd1);
                     chk("small_fs_337",     32'(bus_small.Frame_start), 32'd0);
      step_to(338);  chk("small_fs_338",     32'(bus_small.Frame_start), 32'd1);
      step_to(640);  chk("addr_t640",        32'(bus_full.Addr), 32'd319);
      step_to(641);  chk("addr_hold_641",    32'(bus_full.Addr), 32'd319);
                     chk("rd_off_641",       32'(bus_full.Rd_en), 32'd0);
      step_to(674);  chk("small_fs_674",     32'(bus_small.Frame_start), 32'd1);
      step_to(801);  chk("addr_line1",       32'(bus_full.Addr), 32'd0);
      step_to(1601); chk("addr_line2",       32'(bus_full.Addr), 32'd320);
      step_to(1603); chk("addr_line2_b",     32'(bus_full.Addr), 32'd321);
      step_to(1650);

      // One-cycle mid-frame reset, RAM returns FFF everywhere
      hold_reset(1, 2);
      release_reset();
                     chk("mid_addr_t0",      32'(bus_full.Addr), 32'd0);
                     chk("mid_rd_t0",        32'(bus_full.Rd_en), 32'd0);
      step_to(1);    chk("mid_rd_t1",        32'(bus_full.Rd_en), 32'd1);
      step_to(2);    chk("mid_fs_t2",        32'(bus_full.Frame_start), 32'd1);
                     chk("mid_fs_t2_small",  32'(bus_small.Frame_start), 32'd1);
      step_to(5);    chk("mid_dout_fff",     32'(bus_full.Dout), 32'hFFF);
      step_to(22);   chk("mid_small_blank",  32'(bus_small.Dout), 32'h000);
      step_to(702);  chk("mid_full_blank",   32'(bus_full.Dout), 32'h000);
                     chk("mid_full_nb",      32'(bus_full.Nblank), 32'd0);
      step_to(900);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
